// File: rtl/instr_sequencer_if.sv
// Instruction-memory fetch handshake plus register-file / ALU control bundle
// shared between the sequencer (master) and the memory/datapath (slave).
interface instr_sequencer_if #(
    parameter int PC_W = 8
);
    logic              imem_req;
    logic [PC_W-1:0]   imem_addr;
    logic              imem_ack;
    logic [8:0]        imem_data;

    logic              rf_rd_en;
    logic [1:0]        rf_rd0_addr;
    logic [1:0]        rf_rd1_addr;
    logic              rf_wr_en;
    logic [1:0]        rf_wr_addr;
    logic signed [8:0] rf_wr_data;
    logic signed [8:0] rf_rd0_data;
    logic signed [8:0] rf_rd1_data;

    logic [2:0]        alu_op;
    logic signed [8:0] alu_result;

    modport master (
        output imem_req, imem_addr,
        input  imem_ack, imem_data,
        output rf_rd_en, rf_rd0_addr, rf_rd1_addr,
        output rf_wr_en, rf_wr_addr, rf_wr_data,
        input  rf_rd0_data, rf_rd1_data,
        output alu_op,
        input  alu_result
    );

    modport slave (
        input  imem_req, imem_addr,
        output imem_ack, imem_data,
        input  rf_rd_en, rf_rd0_addr, rf_rd1_addr,
        input  rf_wr_en, rf_wr_addr, rf_wr_data,
        output rf_rd0_data, rf_rd1_data,
        input  alu_op,
        output alu_result
    );
endinterface

// File: rtl/instr_sequencer.sv
// Multi-cycle control FSM: fetches 9-bit instructions over a req/ack
// handshake and sequences register-file read, ALU execute and write-back,
// one instruction at a time. Sole driver of the register-file control pins.
module instr_sequencer #(
    parameter int PC_W          = 8,
    parameter int FETCH_TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    instr_sequencer_if.master bus,
    output logic              busy,
    output logic              halted,
    output logic              fault,
    output logic [7:0]        retired
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_READ,
        S_EXEC,
        S_WB,
        S_HALTED
    } state_t;

    typedef enum logic [2:0] {
        OP_ADD  = 3'b000,
        OP_SUB  = 3'b001,
        OP_AND  = 3'b010,
        OP_OR   = 3'b011,
        OP_SLT  = 3'b100,
        OP_LI   = 3'b101,
        OP_NOP  = 3'b110,
        OP_HALT = 3'b111
    } opcode_t;

    // Last FETCH cycle index without ack before declaring a timeout.
    localparam logic [7:0] TIMEOUT_LAST = 8'(FETCH_TIMEOUT - 1);

    state_t            state_q;
    state_t            state_d;

    logic [PC_W-1:0]   pc_q;
    logic [8:0]        ir_q;
    logic [7:0]        to_cnt_q;
    logic              fault_q;
    logic [7:0]        retired_q;

    logic [1:0]        rd0_addr_q;
    logic [1:0]        rd1_addr_q;
    logic [1:0]        wr_addr_q;
    logic signed [8:0] wr_data_q;
    logic [2:0]        alu_op_q;

    logic              req_c;
    logic              rd_en_c;
    logic              wr_en_c;
    logic              busy_c;
    logic              halted_c;
    logic              retire_c;
    logic              timeout_c;

    opcode_t           opcode;
    logic [1:0]        f_rd;
    logic [1:0]        f_rs;
    logic [1:0]        f_rt;
    logic signed [8:0] imm_sext;

    assign opcode   = opcode_t'(ir_q[8:6]);
    assign f_rd     = ir_q[5:4];
    assign f_rs     = ir_q[3:2];
    assign f_rt     = ir_q[1:0];
    assign imm_sext = {{5{ir_q[3]}}, ir_q[3:0]};

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode and per-state strobes.
    always_comb begin
        state_d   = state_q;
        req_c     = 1'b0;
        rd_en_c   = 1'b0;
        wr_en_c   = 1'b0;
        busy_c    = 1'b1;
        halted_c  = 1'b0;
        retire_c  = 1'b0;
        timeout_c = 1'b0;
        case (state_q)
            S_IDLE: begin
                busy_c = 1'b0;
                if (start) begin
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                req_c = 1'b1;
                if (bus.imem_ack) begin
                    state_d = S_DECODE;
                end else if (to_cnt_q == TIMEOUT_LAST) begin
                    timeout_c = 1'b1;
                    state_d   = S_HALTED;
                end
            end
            S_DECODE: begin
                case (opcode)
                    OP_LI:   state_d = S_WB;
                    OP_NOP: begin
                        retire_c = 1'b1;
                        state_d  = S_FETCH;
                    end
                    OP_HALT: begin
                        retire_c = 1'b1;
                        state_d  = S_HALTED;
                    end
                    default: state_d = S_READ;
                endcase
            end
            S_READ: begin
                rd_en_c = 1'b1;
                state_d = S_EXEC;
            end
            S_EXEC: begin
                state_d = S_WB;
            end
            S_WB: begin
                wr_en_c  = 1'b1;
                retire_c = 1'b1;
                state_d  = S_FETCH;
            end
            S_HALTED: begin
                busy_c   = 1'b0;
                halted_c = 1'b1;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Program counter, instruction register and fetch-timeout counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q     <= '0;
            ir_q     <= '0;
            to_cnt_q <= '0;
        end else if (state_q == S_FETCH) begin
            if (bus.imem_ack) begin
                ir_q <= bus.imem_data;
                pc_q <= pc_q + 1'b1;
            end else begin
                to_cnt_q <= to_cnt_q + 8'd1;
            end
        end else begin
            // Held at zero outside FETCH so every FETCH entry starts a fresh count.
            to_cnt_q <= '0;
        end
    end

    // Sticky fault flag and retired-instruction counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            fault_q   <= 1'b0;
            retired_q <= '0;
        end else begin
            if (timeout_c) begin
                fault_q <= 1'b1;
            end
            if (retire_c) begin
                retired_q <= retired_q + 8'd1;
            end
        end
    end

    // Datapath control registers, loaded on entry to the state that presents
    // them so they are valid for that whole cycle and hold afterwards.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd0_addr_q <= '0;
            rd1_addr_q <= '0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            alu_op_q   <= '0;
        end else begin
            if (state_d == S_READ) begin
                rd0_addr_q <= f_rs;
                rd1_addr_q <= f_rt;
            end
            if (state_d == S_EXEC) begin
                alu_op_q <= ir_q[8:6];
            end
            // wr_data_q doubles as the result register: the ALU result is
            // captured at the end of EXEC, the immediate at the end of DECODE.
            if (state_d == S_WB) begin
                wr_addr_q <= f_rd;
                wr_data_q <= (state_q == S_EXEC) ? bus.alu_result : imm_sext;
            end
        end
    end

    assign bus.imem_req    = req_c;
    assign bus.imem_addr   = pc_q;
    assign bus.rf_rd_en    = rd_en_c;
    assign bus.rf_rd0_addr = rd0_addr_q;
    assign bus.rf_rd1_addr = rd1_addr_q;
    assign bus.rf_wr_en    = wr_en_c;
    assign bus.rf_wr_addr  = wr_addr_q;
    assign bus.rf_wr_data  = wr_data_q;
    assign bus.alu_op      = alu_op_q;

    assign busy    = busy_c;
    assign halted  = halted_c;
    assign fault   = fault_q;
    assign retired = retired_q;

endmodule

// File: tb/tb_instr_sequencer.sv
// Self-checking bench for instr_sequencer: behavioural instruction memory,
// register file and ALU around the DUT, plus an instruction-level reference
// model of program execution and timing.
module tb_instr_sequencer;

    localparam int         PC_W   = 8;
    localparam int         FT     = 15;
    localparam logic [8:0] NOP_W  = 9'b110_000000;
    localparam logic [8:0] HALT_W = 9'b111_000000;

    logic       clk   = 1'b0;
    logic       rst   = 1'b1;
    logic       start = 1'b0;
    logic       busy;
    logic       halted;
    logic       fault;
    logic [7:0] retired;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    instr_sequencer_if #(.PC_W(PC_W)) bus ();

    instr_sequencer #(.PC_W(PC_W), .FETCH_TIMEOUT(FT)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .bus     (bus),
        .busy    (busy),
        .halted  (halted),
        .fault   (fault),
        .retired (retired)
    );

    // Instruction memory: acks after ack_delay wait cycles, never acks at or
    // above stall_from, optionally toggles ack randomly while not requested.
    logic [8:0] prog [256];
    int ack_delay  = 0;
    int stall_from = 1000;
    bit spurious   = 1'b0;
    int wait_cnt   = 0;

    always @(negedge clk) begin
        if (bus.imem_req) begin
            if (int'(bus.imem_addr) >= stall_from) begin
                bus.imem_ack  = 1'b0;
                bus.imem_data = 9'($urandom);
            end else if (wait_cnt >= ack_delay) begin
                bus.imem_ack  = 1'b1;
                bus.imem_data = prog[bus.imem_addr];
                wait_cnt      = 0;
            end else begin
                bus.imem_ack  = 1'b0;
                bus.imem_data = 9'($urandom);
                wait_cnt++;
            end
        end else begin
            wait_cnt      = 0;
            bus.imem_ack  = spurious ? 1'($urandom) : 1'b0;
            bus.imem_data = 9'($urandom);
        end
    end

    // Register file: writes and reads serviced while the strobes are high.
    logic signed [8:0] regs [4];
    always @(negedge clk) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) regs[i] = '0;
            bus.rf_rd0_data = '0;
            bus.rf_rd1_data = '0;
        end else begin
            if (bus.rf_wr_en) regs[bus.rf_wr_addr] = bus.rf_wr_data;
            if (bus.rf_rd_en) begin
                bus.rf_rd0_data = regs[bus.rf_rd0_addr];
                bus.rf_rd1_data = regs[bus.rf_rd1_addr];
            end
        end
    end

    // Combinational ALU.
    always_comb begin
        bus.alu_result = '0;
        case (bus.alu_op)
            3'd0: bus.alu_result = bus.rf_rd0_data + bus.rf_rd1_data;
            3'd1: bus.alu_result = bus.rf_rd0_data - bus.rf_rd1_data;
            3'd2: bus.alu_result = bus.rf_rd0_data & bus.rf_rd1_data;
            3'd3: bus.alu_result = bus.rf_rd0_data | bus.rf_rd1_data;
            3'd4: bus.alu_result = (bus.rf_rd0_data < bus.rf_rd1_data) ? 9'sd1 : 9'sd0;
            default: bus.alu_result = '0;
        endcase
    end

    // Observed behaviour logs.
    int         cyc      = 0;
    int         rise_cyc = 0;
    int         req_run  = 0;
    bit         prev_req = 1'b0;
    logic [10:0] wr_q [$];
    int         lat_q [$];
    int         reqlen_q [$];
    int         both_en  = 0;
    int         any_en   = 0;

    always @(negedge clk) begin
        cyc++;
        if (bus.imem_req) begin
            if (!prev_req) begin
                rise_cyc = cyc;
                req_run  = 0;
            end
            req_run++;
        end else if (prev_req) begin
            reqlen_q.push_back(req_run);
        end
        prev_req = bus.imem_req;
        if (bus.rf_wr_en) begin
            wr_q.push_back({bus.rf_wr_addr, bus.rf_wr_data});
            lat_q.push_back(cyc - rise_cyc + 1);
        end
        if (bus.rf_rd_en && bus.rf_wr_en) both_en++;
        if (bus.rf_rd_en || bus.rf_wr_en) any_en++;
    end

    // Reference model: runs the program at instruction level from zeroed
    // registers and predicts writes, per-instruction timing and retirement.
    logic [10:0] exp_wr [$];
    int          exp_lat [$];
    int          exp_reqlen [$];
    int          exp_cycles;
    logic [7:0]  exp_ret;

    task automatic model_run(input int d);
        logic signed [8:0] m [4];
        logic signed [8:0] a, b, r;
        logic signed [3:0] imm;
        logic [8:0]        ins;
        int                pc;
        int                nret;
        for (int i = 0; i < 4; i++) m[i] = '0;
        exp_wr.delete();
        exp_lat.delete();
        exp_reqlen.delete();
        exp_cycles = 0;
        pc   = 0;
        nret = 0;
        for (int n = 0; n < 300; n++) begin
            ins = prog[pc % 256];
            pc++;
            nret++;
            exp_reqlen.push_back(d + 1);
            if (ins[8:6] == 3'd7) begin
                exp_cycles += d + 2;
                break;
            end else if (ins[8:6] == 3'd6) begin
                exp_cycles += d + 2;
            end else if (ins[8:6] == 3'd5) begin
                imm = ins[3:0];
                r   = imm;
                m[ins[5:4]] = r;
                exp_wr.push_back({ins[5:4], r});
                exp_lat.push_back(d + 3);
                exp_cycles += d + 3;
            end else begin
                a = m[ins[3:2]];
                b = m[ins[1:0]];
                case (ins[8:6])
                    3'd0:    r = a + b;
                    3'd1:    r = a - b;
                    3'd2:    r = a & b;
                    3'd3:    r = a | b;
                    default: r = (a < b) ? 9'sd1 : 9'sd0;
                endcase
                m[ins[5:4]] = r;
                exp_wr.push_back({ins[5:4], r});
                exp_lat.push_back(d + 5);
                exp_cycles += d + 5;
            end
        end
        exp_ret = 8'(nret);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst   = 1'b1;
        start = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        wr_q.delete();
        lat_q.delete();
        reqlen_q.delete();
        both_en = 0;
        any_en  = 0;
    endtask

    // Pulses start and counts busy cycles until halted (bounded).
    task automatic run_prog(input int bound, input bit noisy, output int ncyc, output bit done);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        ncyc = 0;
        done = 1'b0;
        for (int i = 0; i < bound; i++) begin
            if (halted) begin
                done = 1'b1;
                break;
            end
            ncyc += int'(busy);
            start = noisy ? 1'($urandom) : 1'b0;
            @(negedge clk);
        end
        start = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic load_li_add_halt();
        prog[0] = 9'b101_01_0101;   // LI  r1, 5
        prog[1] = 9'b101_10_1101;   // LI  r2, -3
        prog[2] = 9'b000_11_01_10;  // ADD r3, r1, r2
        prog[3] = HALT_W;
    endtask

    task automatic test_reset();
        bit seen;
        prog[0] = 9'b101_11_1111;   // LI r3, -1
        prog[1] = 9'b011_01_10_11;  // OR r1, r2, r3
        prog[2] = NOP_W;
        ack_delay  = 0;
        spurious   = 1'b0;
        stall_from = 3;
        apply_reset();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (bus.imem_req && bus.imem_addr == 8'd3) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        repeat (2) @(negedge clk);
        vectors++;
        if (!seen || bus.imem_req !== 1'b1) begin
            miscompares++;
            $display("FAIL reset.mid_fetch: req=%b addr=%0d expected req=1 addr=3", bus.imem_req, bus.imem_addr);
        end
        vectors++;
        if (retired !== 8'd3) begin
            miscompares++;
            $display("FAIL reset.pre_retired: got %0d expected 3", retired);
        end
        vectors++;
        if ({bus.rf_rd0_addr, bus.rf_rd1_addr, bus.rf_wr_addr, bus.rf_wr_data, bus.alu_op} !==
            {2'd2, 2'd3, 2'd1, 9'h1FF, 3'd3}) begin
            miscompares++;
            $display("FAIL reset.held_ctrl: rd0=%0d rd1=%0d wa=%0d wd=%h op=%0d expected 2 3 1 1ff 3",
                     bus.rf_rd0_addr, bus.rf_rd1_addr, bus.rf_wr_addr, bus.rf_wr_data, bus.alu_op);
        end
        rst = 1'b1;
        repeat (2) @(negedge clk);
        vectors++;
        if (bus.imem_req !== 1'b0 || bus.imem_addr !== 8'd0) begin
            miscompares++;
            $display("FAIL reset.fetch_out: req=%b addr=%0d expected 0 0", bus.imem_req, bus.imem_addr);
        end
        vectors++;
        if ({bus.rf_rd_en, bus.rf_wr_en, bus.rf_rd0_addr, bus.rf_rd1_addr, bus.rf_wr_addr} !== 8'd0) begin
            miscompares++;
            $display("FAIL reset.rf_ctrl: got %b expected 0", {bus.rf_rd_en, bus.rf_wr_en, bus.rf_rd0_addr, bus.rf_rd1_addr, bus.rf_wr_addr});
        end
        vectors++;
        if (bus.rf_wr_data !== 9'd0 || bus.alu_op !== 3'd0) begin
            miscompares++;
            $display("FAIL reset.data_op: wd=%h op=%0d expected 0 0", bus.rf_wr_data, bus.alu_op);
        end
        vectors++;
        if ({busy, halted, fault} !== 3'b000 || retired !== 8'd0) begin
            miscompares++;
            $display("FAIL reset.status: bhf=%b retired=%0d expected 000 0", {busy, halted, fault}, retired);
        end
        rst = 1'b0;
        @(negedge clk);
        vectors++;
        if (busy !== 1'b0 || bus.imem_req !== 1'b0) begin
            miscompares++;
            $display("FAIL reset.idle_hold: busy=%b req=%b expected 0 0", busy, bus.imem_req);
        end
        stall_from = 1000;
    endtask

    task automatic test_li_add_halt();
        logic [10:0] ev [3];
        logic [10:0] got;
        int ncyc;
        bit done;
        ev[0] = {2'd1, 9'h005};
        ev[1] = {2'd2, 9'h1FD};
        ev[2] = {2'd3, 9'h002};
        load_li_add_halt();
        ack_delay = 0;
        spurious  = 1'b0;
        apply_reset();
        run_prog(200, 1'b0, ncyc, done);
        vectors++;
        if (!done) begin
            miscompares++;
            $display("FAIL li_add.done: halted not seen within 200 cycles");
        end
        vectors++;
        if (wr_q.size() !== 3) begin
            miscompares++;
            $display("FAIL li_add.nwrites: got %0d expected 3", wr_q.size());
        end
        for (int i = 0; i < 3; i++) begin
            got = (i < wr_q.size()) ? wr_q[i] : 'x;
            vectors++;
            if (got !== ev[i]) begin
                miscompares++;
                $display("FAIL li_add.write%0d: got %h expected %h", i, got, ev[i]);
            end
        end
        vectors++;
        if (lat_q.size() < 3 || lat_q[2] !== 5) begin
            miscompares++;
            $display("FAIL li_add.add_latency: got %0d expected 5", (lat_q.size() < 3) ? -1 : lat_q[2]);
        end
        vectors++;
        if (halted !== 1'b1 || busy !== 1'b0 || retired !== 8'd4) begin
            miscompares++;
            $display("FAIL li_add.final: halted=%b busy=%b retired=%0d expected 1 0 4", halted, busy, retired);
        end
        vectors++;
        if (ncyc !== 13) begin
            miscompares++;
            $display("FAIL li_add.cycles: got %0d expected 13", ncyc);
        end
    endtask

    task automatic test_wrap_slt();
        logic [10:0] got;
        int ncyc;
        bit done;
        prog[0] = 9'b101_01_1000;                               // LI  r1, -8
        for (int i = 1; i <= 5; i++) prog[i] = 9'b000_01_01_01; // ADD r1, r1, r1
        prog[6]  = 9'b101_10_0001;                              // LI  r2, 1
        prog[7]  = 9'b001_00_01_10;                             // SUB r0, r1, r2
        prog[8]  = 9'b101_10_1101;                              // LI  r2, -3
        prog[9]  = 9'b101_01_0101;                              // LI  r1, 5
        prog[10] = 9'b100_00_10_01;                             // SLT r0, r2, r1
        prog[11] = HALT_W;
        ack_delay = 0;
        spurious  = 1'b0;
        model_run(0);
        apply_reset();
        run_prog(400, 1'b0, ncyc, done);
        vectors++;
        if (!done || wr_q.size() !== exp_wr.size()) begin
            miscompares++;
            $display("FAIL wrap_slt.nwrites: done=%b got %0d expected %0d", done, wr_q.size(), exp_wr.size());
        end
        for (int i = 0; i < exp_wr.size(); i++) begin
            got = (i < wr_q.size()) ? wr_q[i] : 'x;
            vectors++;
            if (got !== exp_wr[i]) begin
                miscompares++;
                $display("FAIL wrap_slt.write%0d: got %h expected %h", i, got, exp_wr[i]);
            end
        end
        got = (wr_q.size() > 7) ? wr_q[7] : 'x;
        vectors++;
        if (got !== {2'd0, 9'h0FF}) begin
            miscompares++;
            $display("FAIL wrap_slt.sub_wrap: got %h expected %h", got, {2'd0, 9'h0FF});
        end
        got = (wr_q.size() > 10) ? wr_q[10] : 'x;
        vectors++;
        if (got !== {2'd0, 9'h001}) begin
            miscompares++;
            $display("FAIL wrap_slt.slt: got %h expected %h", got, {2'd0, 9'h001});
        end
        vectors++;
        if (retired !== 8'd12 || ncyc !== exp_cycles) begin
            miscompares++;
            $display("FAIL wrap_slt.final: retired=%0d cycles=%0d expected 12 %0d", retired, ncyc, exp_cycles);
        end
    endtask

    task automatic test_wait_states();
        logic [10:0] ev [3];
        logic [10:0] got;
        int ncyc;
        bit done;
        ev[0] = {2'd1, 9'h005};
        ev[1] = {2'd2, 9'h1FD};
        ev[2] = {2'd3, 9'h002};
        load_li_add_halt();
        ack_delay = 2;
        spurious  = 1'b1;
        apply_reset();
        run_prog(300, 1'b1, ncyc, done);
        vectors++;
        if (!done || wr_q.size() !== 3) begin
            miscompares++;
            $display("FAIL wait.nwrites: done=%b got %0d expected 3", done, wr_q.size());
        end
        for (int i = 0; i < 3; i++) begin
            got = (i < wr_q.size()) ? wr_q[i] : 'x;
            vectors++;
            if (got !== ev[i]) begin
                miscompares++;
                $display("FAIL wait.write%0d: got %h expected %h", i, got, ev[i]);
            end
        end
        vectors++;
        if (reqlen_q.size() !== 4) begin
            miscompares++;
            $display("FAIL wait.nfetch: got %0d expected 4", reqlen_q.size());
        end
        for (int i = 0; i < reqlen_q.size(); i++) begin
            vectors++;
            if (reqlen_q[i] !== 3) begin
                miscompares++;
                $display("FAIL wait.req_len%0d: got %0d expected 3", i, reqlen_q[i]);
            end
        end
        vectors++;
        if (lat_q.size() < 3 || lat_q[2] !== 7 || ncyc !== 21 || retired !== 8'd4) begin
            miscompares++;
            $display("FAIL wait.timing: lat=%0d cycles=%0d retired=%0d expected 7 21 4",
                     (lat_q.size() < 3) ? -1 : lat_q[2], ncyc, retired);
        end
        spurious  = 1'b0;
        ack_delay = 0;
    endtask

    task automatic test_timeout();
        int n;
        ack_delay  = 0;
        spurious   = 1'b0;
        stall_from = 0;
        apply_reset();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 1;
        while (!halted && n < 100) begin
            @(negedge clk);
            n++;
        end
        vectors++;
        if (n - 1 !== FT) begin
            miscompares++;
            $display("FAIL timeout.cycles: got %0d expected %0d", n - 1, FT);
        end
        vectors++;
        if ({fault, halted, bus.imem_req, busy} !== 4'b1100) begin
            miscompares++;
            $display("FAIL timeout.state: fhrb=%b expected 1100", {fault, halted, bus.imem_req, busy});
        end
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        vectors++;
        if ({fault, halted, bus.imem_req, busy} !== 4'b1100) begin
            miscompares++;
            $display("FAIL timeout.start_ignored: fhrb=%b expected 1100", {fault, halted, bus.imem_req, busy});
        end
        stall_from = 1000;
        apply_reset();
        vectors++;
        if (fault !== 1'b0 || halted !== 1'b0) begin
            miscompares++;
            $display("FAIL timeout.rst_clears: fault=%b halted=%b expected 0 0", fault, halted);
        end
    endtask

    task automatic test_random();
        logic [10:0] got;
        int ncyc;
        int len;
        bit done;
        for (int it = 0; it < 20; it++) begin
            ack_delay = $urandom_range(0, 3);
            spurious  = 1'($urandom_range(0, 1));
            len       = $urandom_range(1, 30);
            for (int i = 0; i < len; i++) prog[i] = {3'($urandom_range(0, 6)), 6'($urandom)};
            prog[len] = HALT_W;
            model_run(ack_delay);
            apply_reset();
            run_prog(3000, 1'b1, ncyc, done);
            vectors++;
            if (!done || ncyc !== exp_cycles || retired !== exp_ret) begin
                miscompares++;
                $display("FAIL random%0d.run: done=%b cycles=%0d retired=%0d expected 1 %0d %0d",
                         it, done, ncyc, retired, exp_cycles, exp_ret);
            end
            vectors++;
            if (wr_q.size() !== exp_wr.size() || reqlen_q.size() !== exp_reqlen.size()) begin
                miscompares++;
                $display("FAIL random%0d.counts: writes=%0d fetches=%0d expected %0d %0d",
                         it, wr_q.size(), reqlen_q.size(), exp_wr.size(), exp_reqlen.size());
            end
            for (int i = 0; i < exp_wr.size(); i++) begin
                got = (i < wr_q.size()) ? wr_q[i] : 'x;
                vectors++;
                if (got !== exp_wr[i] || (i < lat_q.size() && lat_q[i] !== exp_lat[i])) begin
                    miscompares++;
                    $display("FAIL random%0d.write%0d: got %h lat %0d expected %h lat %0d", it, i, got,
                             (i < lat_q.size()) ? lat_q[i] : -1, exp_wr[i], exp_lat[i]);
                end
            end
            for (int i = 0; i < reqlen_q.size() && i < exp_reqlen.size(); i++) begin
                vectors++;
                if (reqlen_q[i] !== exp_reqlen[i]) begin
                    miscompares++;
                    $display("FAIL random%0d.req_len%0d: got %0d expected %0d", it, i, reqlen_q[i], exp_reqlen[i]);
                end
            end
            vectors++;
            if (both_en !== 0) begin
                miscompares++;
                $display("FAIL random%0d.rd_wr_overlap: got %0d cycles expected 0", it, both_en);
            end
        end
        spurious  = 1'b0;
        ack_delay = 0;
    endtask

    task automatic test_nop_wrap();
        for (int i = 0; i < 256; i++) prog[i] = NOP_W;
        ack_delay = 0;
        spurious  = 1'b0;
        apply_reset();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int n = 1; n <= 520; n++) begin
            vectors++;
            if (retired !== 8'((n - 1) / 2)) begin
                miscompares++;
                $display("FAIL nop_wrap.retired@%0d: got %0d expected %0d", n, retired, 8'((n - 1) / 2));
            end
            @(negedge clk);
        end
        vectors++;
        if (any_en !== 0) begin
            miscompares++;
            $display("FAIL nop_wrap.rf_enables: got %0d active cycles expected 0", any_en);
        end
        apply_reset();
    endtask

    initial begin
        for (int i = 0; i < 256; i++) prog[i] = NOP_W;
        test_reset();
        test_li_add_halt();
        test_wrap_slt();
        test_wait_states();
        test_timeout();
        test_random();
        test_nop_wrap();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
